// File: rtl/clk_ctrl_sequencer_if.sv
// Command/response channel between the CSR block and the clock-control sequencer.
// The CSR side is the master; the sequencer is the slave.
interface clk_ctrl_sequencer_if;
    logic       req_valid;
    logic       req_ready;
    logic [1:0] req_cmd;
    logic [2:0] req_div;
    logic       resp_valid;
    logic       resp_ready;
    logic [1:0] resp_code;

    modport master (
        output req_valid, req_cmd, req_div, resp_ready,
        input  req_ready, resp_valid, resp_code
    );

    modport slave (
        input  req_valid, req_cmd, req_div, resp_ready,
        output req_ready, resp_valid, resp_code
    );
endinterface

// File: rtl/clk_ctrl_sequencer.sv
// Glitch-safe sequencer for the clock/reset manager controls: gated divider changes,
// gate/ungate with settle time, and a software reset pulse with completion tracking.
module clk_ctrl_sequencer #(
    parameter int GATE_SETTLE   = 4,
    parameter int DIV_SETTLE    = 8,
    parameter int RST_PULSE_CYC = 16,
    parameter int RST_TIMEOUT   = 1024
) (
    input  logic                 clk_ref,
    input  logic                 rst_ref,
    clk_ctrl_sequencer_if.slave  bus,
    input  logic                 rst_done,
    output logic                 busy,
    output logic                 clk_gate_en,
    output logic [2:0]           clk_div_sel,
    output logic                 rst_ext_n
);
    localparam int MAX_A = (GATE_SETTLE > DIV_SETTLE) ? GATE_SETTLE : DIV_SETTLE;
    localparam int MAX_B = (RST_PULSE_CYC > RST_TIMEOUT) ? RST_PULSE_CYC : RST_TIMEOUT;
    localparam int MAX_P = (MAX_A > MAX_B) ? MAX_A : MAX_B;
    localparam int CW    = $clog2(MAX_P) + 1;

    localparam logic [1:0] CMD_SET_DIV = 2'd0;
    localparam logic [1:0] CMD_GATE    = 2'd1;
    localparam logic [1:0] CMD_SW_RST  = 2'd3;

    localparam logic [1:0] CODE_OK        = 2'd0;
    localparam logic [1:0] CODE_BAD_DIV   = 2'd1;
    localparam logic [1:0] CODE_NOT_READY = 2'd2;
    localparam logic [1:0] CODE_NO_ACK    = 2'd3;

    typedef enum logic [2:0] {
        IDLE, GATE_WAIT, DIV_WAIT, RESTORE_WAIT, RST_PULSE, RST_WAIT, RESP
    } state_t;

    state_t          r_state, w_state;
    logic [CW-1:0]   r_cnt, w_cnt;
    logic            r_gate, w_gate;
    logic [2:0]      r_div, w_div;
    logic            r_rst_n, w_rst_n;
    logic            r_resp_valid, w_resp_valid;
    logic [1:0]      r_resp_code, w_resp_code;
    logic            r_saved_gate, w_saved_gate;
    logic [2:0]      r_new_div, w_new_div;
    logic            r_is_setdiv, w_is_setdiv;
    logic            r_dropped, w_dropped;
    logic            r_busy;
    logic            w_accept;

    assign bus.req_ready  = (r_state == IDLE) && !rst_ref;
    assign bus.resp_valid = r_resp_valid;
    assign bus.resp_code  = r_resp_code;
    assign busy           = r_busy;
    assign clk_gate_en    = r_gate;
    assign clk_div_sel    = r_div;
    assign rst_ext_n      = r_rst_n;
    assign w_accept       = bus.req_valid && bus.req_ready;

    always_comb begin
        w_state      = r_state;
        w_cnt        = (r_cnt == '1) ? r_cnt : r_cnt + 1'b1;
        w_gate       = r_gate;
        w_div        = r_div;
        w_rst_n      = r_rst_n;
        w_resp_valid = r_resp_valid;
        w_resp_code  = r_resp_code;
        w_saved_gate = r_saved_gate;
        w_new_div    = r_new_div;
        w_is_setdiv  = r_is_setdiv;
        w_dropped    = r_dropped;
        case (r_state)
            IDLE: begin
                if (w_accept) begin
                    if (bus.req_cmd != CMD_SW_RST && !rst_done) begin
                        w_state      = RESP;
                        w_resp_valid = 1'b1;
                        w_resp_code  = CODE_NOT_READY;
                    end else if (bus.req_cmd == CMD_SET_DIV) begin
                        if (bus.req_div[2]) begin
                            w_state      = RESP;
                            w_resp_valid = 1'b1;
                            w_resp_code  = CODE_BAD_DIV;
                        end else if (bus.req_div == r_div) begin
                            w_state      = RESP;
                            w_resp_valid = 1'b1;
                            w_resp_code  = CODE_OK;
                        end else begin
                            w_saved_gate = r_gate;
                            w_new_div    = bus.req_div;
                            w_is_setdiv  = 1'b1;
                            w_gate       = 1'b1;
                            w_state      = GATE_WAIT;
                        end
                    end else if (bus.req_cmd == CMD_SW_RST) begin
                        w_rst_n   = 1'b0;
                        w_dropped = 1'b0;
                        w_state   = RST_PULSE;
                    end else begin
                        w_gate      = (bus.req_cmd == CMD_GATE);
                        w_is_setdiv = 1'b0;
                        w_state     = GATE_WAIT;
                    end
                end
            end
            GATE_WAIT: begin
                if (r_cnt == CW'(GATE_SETTLE - 1)) begin
                    if (r_is_setdiv) begin
                        w_div   = r_new_div;
                        w_state = DIV_WAIT;
                    end else begin
                        w_state      = RESP;
                        w_resp_valid = 1'b1;
                        w_resp_code  = CODE_OK;
                    end
                end
            end
            DIV_WAIT: begin
                if (r_cnt == CW'(DIV_SETTLE - 1)) begin
                    w_gate  = r_saved_gate;
                    w_state = RESTORE_WAIT;
                end
            end
            RESTORE_WAIT: begin
                if (r_cnt == CW'(GATE_SETTLE - 1)) begin
                    w_state      = RESP;
                    w_resp_valid = 1'b1;
                    w_resp_code  = CODE_OK;
                end
            end
            RST_PULSE: begin
                // A manager that never drops rst_done did not see the pulse.
                w_dropped = r_dropped | !rst_done;
                if (r_cnt == CW'(RST_PULSE_CYC - 1)) begin
                    w_rst_n = 1'b1;
                    if (w_dropped) begin
                        w_state = RST_WAIT;
                    end else begin
                        w_state      = RESP;
                        w_resp_valid = 1'b1;
                        w_resp_code  = CODE_NO_ACK;
                    end
                end
            end
            RST_WAIT: begin
                if (rst_done && r_dropped) begin
                    w_state      = RESP;
                    w_resp_valid = 1'b1;
                    w_resp_code  = CODE_OK;
                end else if (r_cnt == CW'(RST_TIMEOUT - 1)) begin
                    w_state      = RESP;
                    w_resp_valid = 1'b1;
                    w_resp_code  = CODE_NO_ACK;
                end
            end
            RESP: begin
                if (bus.resp_ready) begin
                    w_state      = IDLE;
                    w_resp_valid = 1'b0;
                end
            end
            default: w_state = IDLE;
        endcase
        if (w_state != r_state) w_cnt = '0;
    end

    always_ff @(posedge clk_ref) begin
        if (rst_ref) begin
            r_state      <= IDLE;
            r_cnt        <= '0;
            r_gate       <= 1'b0;
            r_div        <= 3'b000;
            r_rst_n      <= 1'b1;
            r_resp_valid <= 1'b0;
            r_resp_code  <= 2'd0;
            r_saved_gate <= 1'b0;
            r_new_div    <= 3'b000;
            r_is_setdiv  <= 1'b0;
            r_dropped    <= 1'b0;
            r_busy       <= 1'b0;
        end else begin
            r_state      <= w_state;
            r_cnt        <= w_cnt;
            r_gate       <= w_gate;
            r_div        <= w_div;
            r_rst_n      <= w_rst_n;
            r_resp_valid <= w_resp_valid;
            r_resp_code  <= w_resp_code;
            r_saved_gate <= w_saved_gate;
            r_new_div    <= w_new_div;
            r_is_setdiv  <= w_is_setdiv;
            r_dropped    <= w_dropped;
            r_busy       <= (w_state != IDLE);
        end
    end
endmodule

// File: tb/tb_clk_ctrl_sequencer.sv
// Bench for clk_ctrl_sequencer: a timeline model derived from the command rules is
// compared every cycle, plus hand-computed literal checks on directed sequences.
module tb_clk_ctrl_sequencer;
    localparam int GS  = 4;
    localparam int DS  = 8;
    localparam int RPC = 16;
    localparam int RTO = 1024;
    localparam int NONE = 1 << 30;

    logic       clk_ref = 1'b0;
    logic       rst_ref = 1'b1;
    logic       rst_done = 1'b1;
    logic       busy, clk_gate_en, rst_ext_n;
    logic [2:0] clk_div_sel;

    clk_ctrl_sequencer_if bus();

    clk_ctrl_sequencer #(
        .GATE_SETTLE(GS), .DIV_SETTLE(DS), .RST_PULSE_CYC(RPC), .RST_TIMEOUT(RTO)
    ) dut (
        .clk_ref(clk_ref), .rst_ref(rst_ref), .bus(bus), .rst_done(rst_done),
        .busy(busy), .clk_gate_en(clk_gate_en), .clk_div_sel(clk_div_sel),
        .rst_ext_n(rst_ext_n)
    );

    always #5 clk_ref = ~clk_ref;

    int checks = 0;
    int errors = 0;

    task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %0h expected %0h at %0t", nm, act, exp, $time);
        end
    endtask

    // Manager model: 0 = static level, 1 = drop in pulse then reassert 300 cycles
    // after release, 2 = never drop, 3 = drop and never reassert.
    int   mgr_mode  = 0;
    logic rd_static = 1'b1;
    int   rel_cnt   = 0;
    always @(negedge clk_ref) begin
        case (mgr_mode)
            0: rst_done = rd_static;
            1: begin
                if (!rst_ext_n) begin
                    rst_done = 1'b0;
                    rel_cnt  = 0;
                end else if (!rst_done) begin
                    rel_cnt++;
                    if (rel_cnt == 300) rst_done = 1'b1;
                end
            end
            2: rst_done = 1'b1;
            default: if (!rst_ext_n) rst_done = 1'b0;
        endcase
    end

    // Timeline model: m_k is the cycle number since the accept edge (cycle 1 follows it).
    bit         m_on = 0, m_idle = 1, m_dropped;
    int         m_k, m_resp_at, m_kind;  // kind: 0 immediate, 1 set_div, 2 gate/ungate, 3 sw_reset
    logic       m_gate, m_new_gate;
    logic [2:0] m_div, m_new_div;
    logic [1:0] m_code;

    always @(posedge clk_ref) begin
        if (rst_ref) begin
            m_on = 1; m_idle = 1; m_gate = 0; m_div = 0; m_k = 0;
        end else if (m_on) begin
            if (m_idle) begin
                if (bus.req_valid) begin
                    m_idle = 0; m_k = 1; m_kind = 0; m_resp_at = 1; m_code = 2'd0;
                    m_new_gate = m_gate; m_new_div = m_div;
                    if (bus.req_cmd != 2'd3 && !rst_done) m_code = 2'd2;
                    else if (bus.req_cmd == 2'd0 && bus.req_div > 3'd3) m_code = 2'd1;
                    else if (bus.req_cmd == 2'd0 && bus.req_div == m_div) m_code = 2'd0;
                    else if (bus.req_cmd == 2'd0) begin
                        m_kind = 1; m_new_div = bus.req_div; m_resp_at = 1 + 2 * GS + DS;
                    end else if (bus.req_cmd == 2'd3) begin
                        m_kind = 3; m_resp_at = NONE; m_dropped = 0;
                    end else begin
                        m_kind = 2; m_new_gate = (bus.req_cmd == 2'd1); m_resp_at = 1 + GS;
                    end
                end
            end else begin
                if (m_kind == 3 && m_resp_at == NONE) begin
                    if (m_k <= RPC) begin
                        if (!rst_done) m_dropped = 1;
                        if (m_k == RPC && !m_dropped) begin m_resp_at = RPC + 1; m_code = 2'd3; end
                    end else if (rst_done) begin
                        m_resp_at = m_k + 1; m_code = 2'd0;
                    end else if (m_k == RPC + RTO) begin
                        m_resp_at = m_k + 1; m_code = 2'd3;
                    end
                end
                if (m_k >= m_resp_at && bus.resp_ready) begin
                    m_idle = 1; m_gate = m_new_gate; m_div = m_new_div;
                end else begin
                    m_k++;
                end
            end
        end
        #1;
        if (m_on) begin
            logic       e_gate, e_rstn, e_rv;
            logic [2:0] e_div;
            e_gate = m_gate; e_div = m_div; e_rstn = 1'b1; e_rv = 1'b0;
            if (!m_idle) begin
                if (m_kind == 1) begin
                    e_gate = (m_k <= GS + DS) ? 1'b1 : m_new_gate;
                    e_div  = (m_k >= 1 + GS) ? m_new_div : m_div;
                end else if (m_kind == 2) begin
                    e_gate = m_new_gate;
                end else if (m_kind == 3) begin
                    e_rstn = (m_k > RPC);
                end
                e_rv = (m_k >= m_resp_at);
            end
            chk("mdl_gate", clk_gate_en, e_gate);
            chk("mdl_div", clk_div_sel, e_div);
            chk("mdl_rst_ext_n", rst_ext_n, e_rstn);
            chk("mdl_resp_valid", bus.resp_valid, e_rv);
            chk("mdl_busy", busy, !m_idle);
            chk("mdl_req_ready", bus.req_ready, m_idle && !rst_ref);
            if (e_rv) chk("mdl_resp_code", bus.resp_code, m_code);
        end
    end

    // Presents a command for one edge; returns at the negedge inside cycle 1.
    task automatic send(input logic [1:0] cmd, input logic [2:0] div);
        @(negedge clk_ref);
        bus.req_valid = 1'b1; bus.req_cmd = cmd; bus.req_div = div;
        @(negedge clk_ref);
        bus.req_valid = 1'b0;
    endtask

    task automatic cyc(input int n);
        repeat (n) @(negedge clk_ref);
    endtask

    task automatic wait_idle();
        int n = 0;
        while ((busy || bus.resp_valid) && n < 3000) begin
            @(negedge clk_ref); n++;
        end
        chk("idle_timeout", (busy || bus.resp_valid), 0);
    endtask

    initial begin
        int k, low;
        bus.req_valid = 0; bus.req_cmd = 0; bus.req_div = 0; bus.resp_ready = 1;
        cyc(3);
        rst_ref = 0; #1;
        chk("rst_gate", clk_gate_en, 0); chk("rst_div", clk_div_sel, 0);
        chk("rst_ext_n", rst_ext_n, 1);  chk("rst_resp_valid", bus.resp_valid, 0);
        chk("rst_resp_code", bus.resp_code, 0); chk("rst_busy", busy, 0);
        chk("rst_req_ready", bus.req_ready, 1);

        // Divider change with a stalled consumer
        bus.resp_ready = 0;
        send(2'd0, 3'd2);
        chk("t1_gate_c1", clk_gate_en, 1); chk("t1_ready_c1", bus.req_ready, 0);
        cyc(3);  chk("t1_div_c4", clk_div_sel, 0);
        cyc(1);  chk("t1_div_c5", clk_div_sel, 2);
        cyc(7);  chk("t1_gate_c12", clk_gate_en, 1);
        cyc(1);  chk("t1_gate_c13", clk_gate_en, 0);
        cyc(3);  chk("t1_rv_c16", bus.resp_valid, 0);
        cyc(1);  chk("t1_rv_c17", bus.resp_valid, 1); chk("t1_code", bus.resp_code, 0);
        cyc(5);  chk("t1_rv_held", bus.resp_valid, 1); chk("t1_code_held", bus.resp_code, 0);
        bus.resp_ready = 1;
        cyc(1);  chk("t1_rv_done", bus.resp_valid, 0); chk("t1_busy_done", busy, 0);
        chk("t1_ready_done", bus.req_ready, 1);

        // Divider change while gated keeps the gate high
        send(2'd1, 3'd0); wait_idle();
        chk("t2_gated", clk_gate_en, 1);
        send(2'd0, 3'd3);
        cyc(12); chk("t2_gate_c13", clk_gate_en, 1);
        wait_idle(); chk("t2_div", clk_div_sel, 3);
        send(2'd0, 3'd3);
        chk("t2_same_rv", bus.resp_valid, 1); chk("t2_same_code", bus.resp_code, 0);
        chk("t2_same_gate", clk_gate_en, 1);
        wait_idle();
        send(2'd2, 3'd0);
        chk("t2_ungate_c1", clk_gate_en, 0);
        cyc(3); chk("t2_ungate_rv_c4", bus.resp_valid, 0);
        cyc(1); chk("t2_ungate_rv_c5", bus.resp_valid, 1);
        wait_idle();

        // Rejected commands
        send(2'd0, 3'd5);
        chk("t3_bad_code", bus.resp_code, 1); chk("t3_bad_div", clk_div_sel, 3);
        wait_idle();
        rd_static = 0;
        send(2'd0, 3'd1);
        chk("t3_nr_code", bus.resp_code, 2); chk("t3_nr_div", clk_div_sel, 3);
        wait_idle();
        send(2'd1, 3'd0);
        chk("t3_nr_gate_code", bus.resp_code, 2); chk("t3_nr_gate", clk_gate_en, 0);
        wait_idle();

        // Software reset, well-behaved manager
        mgr_mode = 1;
        send(2'd3, 3'd0);
        k = 1; low = 0;
        while (!rst_ext_n && k < 100) begin low++; @(negedge clk_ref); k++; end
        chk("t4_pulse_len", low, RPC);
        while (!bus.resp_valid && k < 3000) begin @(negedge clk_ref); k++; end
        chk("t4_ok_cycle", k, 317); chk("t4_ok_code", bus.resp_code, 0);
        wait_idle();
        // Manager never drops rst_done
        mgr_mode = 2;
        send(2'd3, 3'd0);
        k = 1;
        while (!bus.resp_valid && k < 3000) begin @(negedge clk_ref); k++; end
        chk("t4_nodrop_cycle", k, 17); chk("t4_nodrop_code", bus.resp_code, 3);
        wait_idle();
        // Manager never reasserts rst_done
        mgr_mode = 3;
        send(2'd3, 3'd0);
        k = 1;
        while (!bus.resp_valid && k < 3000) begin @(negedge clk_ref); k++; end
        chk("t4_tmo_cycle", k, 1041); chk("t4_tmo_code", bus.resp_code, 3);
        wait_idle();
        mgr_mode = 0; rd_static = 1;

        // Reset aborts in mid-sequence
        send(2'd0, 3'd1);
        cyc(2); chk("t5_gate_c3", clk_gate_en, 1);
        rst_ref = 1;
        cyc(1); chk("t5_gate", clk_gate_en, 0); chk("t5_div", clk_div_sel, 0);
        chk("t5_rv", bus.resp_valid, 0); chk("t5_ready_in_rst", bus.req_ready, 0);
        rst_ref = 0; #1; chk("t5_ready", bus.req_ready, 1);
        send(2'd3, 3'd0);
        cyc(7); chk("t5_rstn_c8", rst_ext_n, 0);
        rst_ref = 1;
        cyc(1); chk("t5_rstn", rst_ext_n, 1); chk("t5_rv2", bus.resp_valid, 0);
        chk("t5_busy", busy, 0);
        rst_ref = 0; #1; chk("t5_ready2", bus.req_ready, 1);

        // Back-to-back requests with valid held high
        @(negedge clk_ref);
        bus.req_valid = 1; bus.req_cmd = 2'd1; bus.req_div = 0;
        k = 0;
        for (int i = 0; i < 30; i++) begin
            if (bus.req_ready) k++;
            @(negedge clk_ref);
        end
        bus.req_valid = 0;
        chk("t6_accepts", k, 5);
        wait_idle();

        cyc(2);
        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end
endmodule
